// File: rtl/trail_collision_checker_if.sv
// trail_collision_checker_if
//   Read-port handshake between the collision checker and the trail RAM arbiter.
//   Signals:
//     rd_req   requester -> arbiter  read request, held until rd_gnt
//     rd_addr  requester -> arbiter  read address, stable while rd_req is high
//     rd_gnt   arbiter -> requester  address accepted this cycle
//     rd_valid arbiter -> requester  rd_data valid, one pulse per grant
//     rd_data  arbiter -> requester  trail RAM read data
//   Modports: master (checker side), slave (arbiter side).
interface trail_collision_checker_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_gnt,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_gnt,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/trail_collision_checker.sv
// trail_collision_checker
//   Per-frame collision detector. On every synchronised frame tick while the game is in PLAY it
//   looks up the trail-map cell ahead of each bike (blue first, then red) and raises a sticky
//   crash flag for a bike whose lookahead cell is occupied or off the play field.
//   Optional feature macro: TRAIL_HEADON_EN -- also flags a head-on collision (both lookahead
//   cells equal, or the bikes about to swap cells) as a crash for both players.
// Ports:
//   Clk, Reset           system clock; synchronous active-high reset
//   frame_clk            frame strobe, asynchronous to Clk
//   Game_State           3'b010 = PLAY
//   Blue_X/Y, Red_X/Y    bike cell coordinates
//   Blue_dir, Red_dir    00 down, 01 up, 10 right, 11 left
//   rd                   trail RAM read port (req/gnt/valid handshake), master side
//   crash_blue/red       sticky crash flags
//   check_done           1-cycle pulse at the end of each check
//   busy                 high from tick accept until check_done
module trail_collision_checker #(
  parameter int unsigned GRID_W = 224,
  parameter int unsigned GRID_H = 224,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic [2:0]                Game_State,
  input  logic [7:0]                Blue_X,
  input  logic [7:0]                Blue_Y,
  input  logic [7:0]                Red_X,
  input  logic [7:0]                Red_Y,
  input  logic [1:0]                Blue_dir,
  input  logic [1:0]                Red_dir,
  trail_collision_checker_if.master rd,
  output logic                      crash_blue,
  output logic                      crash_red,
  output logic                      check_done,
  output logic                      busy
);

  localparam logic [2:0]        PlayState = 3'b010;
  localparam logic signed [8:0] GridWS    = 9'(GRID_W);
  localparam logic signed [8:0] GridHS    = 9'(GRID_H);

  typedef enum logic [2:0] {
    StIdle, StCalcB, StReqB, StWaitB, StCalcR, StReqR, StWaitR, StResolve
  } state_e;

  state_e r_state, w_state_nxt;

  logic [2:0]        r_fsync;
  logic [7:0]        r_bx, r_by, r_rx, r_ry;
  logic [1:0]        r_bdir, r_rdir;
  logic              r_pend_b, r_pend_r;
  logic              r_crash_b, r_crash_r;
  logic [ADDR_W-1:0] r_addr;

  logic              w_play, w_tick;
  logic [7:0]        w_cx, w_cy;
  logic [1:0]        w_dir;
  logic signed [8:0] w_lx, w_ly;
  logic              w_oob;
  logic [ADDR_W-1:0] w_addr;
  logic              w_cell_hit;
  logic              w_headon;
  logic              w_unused_data;

  assign w_play        = (Game_State == PlayState);
  // r_fsync[1:0] is the synchroniser, r_fsync[2] the delayed copy for edge detection
  assign w_tick        = r_fsync[1] & ~r_fsync[2];
  assign w_cell_hit    = (rd.rd_data[2:0] != 3'b000);
  assign w_unused_data = ^rd.rd_data[DATA_W-1:3];

  // Lookahead for whichever bike the FSM is currently evaluating
  always_comb begin
    w_cx  = (r_state == StCalcR) ? r_rx   : r_bx;
    w_cy  = (r_state == StCalcR) ? r_ry   : r_by;
    w_dir = (r_state == StCalcR) ? r_rdir : r_bdir;
    w_lx  = $signed({1'b0, w_cx});
    w_ly  = $signed({1'b0, w_cy});
    unique case (w_dir)
      2'b00:   w_ly = w_ly + 9'sd1;
      2'b01:   w_ly = w_ly - 9'sd1;
      2'b10:   w_lx = w_lx + 9'sd1;
      default: w_lx = w_lx - 9'sd1;
    endcase
    w_oob  = (w_lx < 9'sd0) || (w_lx >= GridWS) || (w_ly < 9'sd0) || (w_ly >= GridHS);
    w_addr = ADDR_W'(w_ly[7:0]) * ADDR_W'(GRID_W) + ADDR_W'(w_lx[7:0]);
  end

`ifdef TRAIL_HEADON_EN
  logic [8:0] r_lbx, r_lby, r_lrx, r_lry;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lbx <= '0;
      r_lby <= '0;
      r_lrx <= '0;
      r_lry <= '0;
    end else if (r_state == StCalcB) begin
      r_lbx <= w_lx;
      r_lby <= w_ly;
    end else if (r_state == StCalcR) begin
      r_lrx <= w_lx;
      r_lry <= w_ly;
    end
  end

  // Same target cell, or each bike heading into the other's current cell
  assign w_headon = ((r_lbx == r_lrx) && (r_lby == r_lry)) ||
                    ((r_lbx == {1'b0, r_rx}) && (r_lby == {1'b0, r_ry}) &&
                     (r_lrx == {1'b0, r_bx}) && (r_lry == {1'b0, r_by}));
`else
  assign w_headon = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // FSM next state; leaving PLAY aborts from any state
  always_comb begin
    w_state_nxt = r_state;
    if (!w_play) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle:    if (w_tick) w_state_nxt = StCalcB;
        StCalcB:   w_state_nxt = w_oob ? StCalcR : StReqB;
        StReqB:    if (rd.rd_gnt) w_state_nxt = StWaitB;
        StWaitB:   if (rd.rd_valid) w_state_nxt = StCalcR;
        StCalcR:   w_state_nxt = w_oob ? StResolve : StReqR;
        StReqR:    if (rd.rd_gnt) w_state_nxt = StWaitR;
        StWaitR:   if (rd.rd_valid) w_state_nxt = StResolve;
        StResolve: w_state_nxt = StIdle;
        default:   w_state_nxt = StIdle;
      endcase
    end
  end

  always_comb begin
    rd.rd_req  = (r_state == StReqB) || (r_state == StReqR);
    rd.rd_addr = r_addr;
    busy       = (r_state != StIdle);
    check_done = (r_state == StResolve);
    crash_blue = r_crash_b;
    crash_red  = r_crash_r;
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_fsync <= '0;
    else       r_fsync <= {r_fsync[1:0], frame_clk};
  end

  // Datapath: input latch, read address, pending hits and sticky flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bx      <= '0;
      r_by      <= '0;
      r_rx      <= '0;
      r_ry      <= '0;
      r_bdir    <= '0;
      r_rdir    <= '0;
      r_pend_b  <= 1'b0;
      r_pend_r  <= 1'b0;
      r_crash_b <= 1'b0;
      r_crash_r <= 1'b0;
      r_addr    <= '0;
    end else if (!w_play) begin
      r_pend_b  <= 1'b0;
      r_pend_r  <= 1'b0;
      r_crash_b <= 1'b0;
      r_crash_r <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_tick) begin
            r_bx     <= Blue_X;
            r_by     <= Blue_Y;
            r_rx     <= Red_X;
            r_ry     <= Red_Y;
            r_bdir   <= Blue_dir;
            r_rdir   <= Red_dir;
            r_pend_b <= 1'b0;
            r_pend_r <= 1'b0;
          end
        end
        StCalcB: begin
          if (w_oob) r_pend_b <= 1'b1;
          else       r_addr   <= w_addr;
        end
        StWaitB: if (rd.rd_valid) r_pend_b <= r_pend_b | w_cell_hit;
        StCalcR: begin
          if (w_oob) r_pend_r <= 1'b1;
          else       r_addr   <= w_addr;
        end
        StWaitR: if (rd.rd_valid) r_pend_r <= r_pend_r | w_cell_hit;
        StResolve: begin
          r_crash_b <= r_crash_b | r_pend_b | w_headon;
          r_crash_r <= r_crash_r | r_pend_r | w_headon;
        end
        default: ;
      endcase
    end
  end

endmodule
